kbd_matrix: RTL and testbench
=============================

KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have parameter CLEAR_ON_ERROR, default 1; when 1, a keyboard self-test or error byte releases all keys.
REQ-002 SHALL have parameter PAUSE_SKIP, default 7; the number of bytes discarded after an E1 prefix.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (the master clock also used by the CPU and gate array).
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port scan_valid, input, 1 bit: one-cycle strobe marking a received PS/2 byte.
REQ-006 SHALL have port scan_code, input, 8 bits: the PS/2 set-2 byte, sampled only when scan_valid=1.
REQ-007 SHALL have port kbmat, output, 64 bits: the key matrix for the gate array, index = row*8+col; 0 = pressed, 1 = released.
REQ-008 SHALL have port key_event, output, 1 bit: one-cycle pulse whenever kbmat changes.

Function
REQ-009 SHALL run a parser FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and SKIP (after E1).
REQ-010 SHALL apply these transitions on each scan_valid:
- IDLE: E0->EXT; F0->BRK; E1->SKIP (load skip counter with PAUSE_SKIP); any other byte is a make code, stay in IDLE.
- EXT: F0->EXT_BRK; other byte is an extended make code, then IDLE.
- BRK: byte is a break code, then IDLE.
- EXT_BRK: byte is an extended break code, then IDLE.
- SKIP: decrement the counter; enter IDLE when the counter reaches 0.
REQ-011 SHALL translate each make or break code through a combinational lookup: 9-bit key {ext, code} -> {hit, idx[5:0]}.
REQ-012 SHALL clear kbmat[idx] on a make code with hit=1, and set kbmat[idx] on a break code with hit=1.
REQ-013 SHALL ignore codes with hit=0, leaving kbmat unchanged and key_event low; this includes E0 12 and E0 59 (fake shifts).
REQ-014 SHALL register kbmat so that it updates on the clock edge that samples the final byte of a sequence; kbmat is visible the cycle after the strobe (latency 1).
REQ-015 SHALL assert key_event in the same cycle the new kbmat first appears, only when the value actually changes; a repeated make (typematic) SHALL NOT pulse key_event.
REQ-016 SHALL, when CLEAR_ON_ERROR=1 and state is IDLE, treat bytes AA, FC, 00 and FF as follows: set kbmat to all ones, pulse key_event if kbmat changed, stay in IDLE.
REQ-017 SHALL ignore a byte with scan_valid=0; the FSM and kbmat hold.
REQ-018 SHALL accept back-to-back strobes on consecutive cycles with no byte loss.
REQ-019 SHALL, when a prefix byte (E0, F0 or E1) arrives while in EXT, BRK or EXT_BRK, restart prefix decoding from that byte as if in IDLE.
REQ-020 SHALL accept any number of simultaneous pressed keys; there is no rollover limit.

Reset
REQ-021 SHALL, while reset=1, hold the FSM in IDLE, the skip counter at 0, kbmat at all ones and key_event at 0.
REQ-022 SHALL ignore scan_valid during the reset cycle; a sequence interrupted by reset is abandoned, and the next byte is decoded from IDLE.

Structure
REQ-023 SHALL place the FSM state enum, prefix constants (E0, F0, E1, AA, FC), the KBMAT_IDLE constant (all ones) and the keymap table constant in a shared package, kbd_pkg.
REQ-024 SHALL fix these keymap entries in kbd_pkg:
- 1C ('A') -> 44
- 12 (L-Shift) -> 62
- 5A (Enter) -> 6
- {E0,75} (Up) -> 3
- 29 (Space) -> 5
REQ-025 SHALL implement the lookup as one combinational sub-module, kbd_keymap, instantiated once.
REQ-026 SHALL be integrated between the PS/2 byte receiver and the gate array's kbmat input, clocked from the master clock.

Verification
REQ-027 SHALL cover a single key: bytes 1C, then F0 1C -> kbmat[44]=0 one cycle after 1C, back to 1 after 1C of the break; key_event pulses twice.
REQ-028 SHALL cover an extended key: bytes E0 75, then E0 F0 75 -> kbmat[3] cleared then set; bit 3 is untouched by E0 alone, and a plain 75 does not affect bit 3.
REQ-029 SHALL cover multiple keys with typematic repeat: 12, 1C, 1C, 1C -> bits 62 and 44 both 0; key_event pulses exactly twice; all other bits stay 1.
REQ-030 SHALL cover Pause: E1 14 77 E1 F0 14 F0 77 -> kbmat unchanged, no key_event; then a following 29 clears bit 5.
REQ-031 SHALL cover error and reset: with bits 44 and 62 pressed, byte AA -> kbmat=all ones plus key_event; E0 then reset for one cycle, then 75 -> 75 is treated as a non-extended code, so bit 3 stays 1.
REQ-032 SHALL cover back-to-back strobes: F0 and 1C on consecutive cycles after a 1C make -> bit 44 released two cycles after F0.

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_pkg
//  Purpose  : Shared definitions for the PS/2 set-2 to key-matrix translator:
//             parser state encoding, prefix / status byte values, the idle
//             matrix value and the scan-code to matrix-index table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // Parser states: what prefix bytes have been seen so far.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // waiting for a fresh sequence
    ST_EXT     = 3'd1,  // E0 seen
    ST_BRK     = 3'd2,  // F0 seen
    ST_EXT_BRK = 3'd3,  // E0 F0 seen
    ST_SKIP    = 3'd4   // discarding the tail of the Pause sequence
  } state_t;

  // Prefix and keyboard status bytes
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

  // Matrix with every key released (active-low key lines)
  localparam logic [63:0] KBMAT_IDLE = {64{1'b1}};

  // One keymap entry: 9-bit key {ext, code} and its row*8+col matrix index.
  typedef struct packed {
    logic [8:0] key;
    logic [5:0] idx;
  } keymap_entry_t;

  localparam int KEYMAP_N = 24;

  // Every key value in this table must be unique. Fake shifts (E0 12,
  // E0 59) are deliberately absent so they never reach the matrix.
  localparam keymap_entry_t KEYMAP [KEYMAP_N] = '{
    '{9'h01C, 6'd44},  // A
    '{9'h012, 6'd62},  // Left shift
    '{9'h059, 6'd61},  // Right shift
    '{9'h05A, 6'd6 },  // Enter
    '{9'h175, 6'd3 },  // Cursor up    (E0 75)
    '{9'h172, 6'd2 },  // Cursor down  (E0 72)
    '{9'h16B, 6'd8 },  // Cursor left  (E0 6B)
    '{9'h174, 6'd1 },  // Cursor right (E0 74)
    '{9'h029, 6'd5 },  // Space
    '{9'h014, 6'd23},  // Left control
    '{9'h076, 6'd58},  // Escape
    '{9'h00D, 6'd60},  // Tab
    '{9'h066, 6'd47},  // Backspace
    '{9'h032, 6'd54},  // B
    '{9'h01B, 6'd52},  // S
    '{9'h023, 6'd53},  // D
    '{9'h02B, 6'd45},  // F
    '{9'h075, 6'd12},  // Keypad 8 (same code as Up, without E0)
    '{9'h070, 6'd15},  // Keypad 0
    '{9'h016, 6'd57},  // 1
    '{9'h01E, 6'd56},  // 2
    '{9'h026, 6'd49},  // 3
    '{9'h015, 6'd59},  // Q
    '{9'h01D, 6'd51}   // W
  };

  // Bytes the keyboard sends after self-test or on an internal error.
  function automatic logic is_error_byte(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_BAT_FAIL) ||
           (b == 8'h00)     || (b == 8'hFF);
  endfunction

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/kbd_keymap.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_keymap
//  Purpose  : Combinational lookup of a 9-bit {ext, code} key into the
//             64-entry key matrix.
//  Ports    : key [8:0]  in  - {extended flag, scan code}
//             hit        out - key is present in the table
//             idx [5:0]  out - matrix index (row*8+col), 0 when hit=0
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_keymap
  import kbd_pkg::*;
(
  input  logic [8:0] key,
  output logic       hit,
  output logic [5:0] idx
);

  logic [KEYMAP_N-1:0] match;

  // One comparator per table entry; table keys are unique so at most one
  // match bit is ever set.
  generate
    for (genvar i = 0; i < KEYMAP_N; i++) begin : g_entry
      assign match[i] = (KEYMAP[i].key == key);
    end
  endgenerate

  always_comb begin
    hit = |match;
    idx = 6'd0;
    for (int i = 0; i < KEYMAP_N; i++) begin
      if (match[i]) begin
        idx = KEYMAP[i].idx;
      end
    end
  end

endmodule : kbd_keymap
`default_nettype wire

// File: rtl/kbd_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_matrix
//  Purpose  : Turns the PS/2 set-2 byte stream into the 64-bit active-low key
//             matrix read by the gate array. Handles E0/F0 prefixes, skips
//             the Pause (E1) sequence and releases all keys on keyboard
//             self-test / error bytes.
//  Params   : CLEAR_ON_ERROR - 1: AA/FC/00/FF in IDLE release all keys
//             PAUSE_SKIP     - bytes discarded after an E1 prefix
//  Ports    : clk          in  - master clock
//             reset        in  - synchronous, active-high
//             scan_valid   in  - one-cycle strobe for a received byte
//             scan_code    in  - received byte [7:0]
//             kbmat        out - key matrix [63:0], 0 = pressed
//             key_event    out - one-cycle pulse when kbmat changes
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_matrix
  import kbd_pkg::*;
#(
  parameter int CLEAR_ON_ERROR = 1,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  output logic [63:0] kbmat,
  output logic        key_event
);

  localparam logic [7:0] SKIP_LOAD = 8'(PAUSE_SKIP);

  state_t      state;
  state_t      state_next;
  logic [7:0]  skip_cnt;
  logic [7:0]  skip_next;

  logic        is_make;
  logic        is_break;
  logic        do_clear;
  logic        lookup_ext;
  logic        hit;
  logic [5:0]  idx;
  logic [63:0] kbmat_next;

  // The extended flag of the lookup key comes straight from the state, so
  // the lookup never depends on the decode of the current byte.
  assign lookup_ext = (state == ST_EXT) || (state == ST_EXT_BRK);

  kbd_keymap u_keymap (
    .key (({lookup_ext, scan_code})),
    .hit (hit),
    .idx (idx)
  );

  // --------------------------------------------------------------------------
  // Parser state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // --------------------------------------------------------------------------
  // Parser next-state and decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    is_make    = 1'b0;
    is_break   = 1'b0;
    do_clear   = 1'b0;

    if (scan_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (scan_code == SC_EXT) begin
            state_next = ST_EXT;
          end else if (scan_code == SC_BRK) begin
            state_next = ST_BRK;
          end else if (scan_code == SC_PAUSE) begin
            // A zero skip length means there is nothing to discard.
            state_next = (SKIP_LOAD != 8'd0) ? ST_SKIP : ST_IDLE;
            skip_next  = SKIP_LOAD;
          end else if ((CLEAR_ON_ERROR != 0) && is_error_byte(scan_code)) begin
            do_clear = 1'b1;
          end else begin
            is_make = 1'b1;
          end
        end

        ST_EXT: begin
          // A new prefix restarts decoding; F0 here completes E0 F0.
          if (scan_code == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else if (scan_code == SC_EXT) begin
            state_next = ST_EXT;
          end else if (scan_code == SC_PAUSE) begin
            state_next = (SKIP_LOAD != 8'd0) ? ST_SKIP : ST_IDLE;
            skip_next  = SKIP_LOAD;
          end else begin
            is_make    = 1'b1;
            state_next = ST_IDLE;
          end
        end

        ST_BRK, ST_EXT_BRK: begin
          if (scan_code == SC_EXT) begin
            state_next = ST_EXT;
          end else if (scan_code == SC_BRK) begin
            state_next = ST_BRK;
          end else if (scan_code == SC_PAUSE) begin
            state_next = (SKIP_LOAD != 8'd0) ? ST_SKIP : ST_IDLE;
            skip_next  = SKIP_LOAD;
          end else begin
            is_break   = 1'b1;
            state_next = ST_IDLE;
          end
        end

        ST_SKIP: begin
          if (skip_cnt <= 8'd1) begin
            skip_next  = 8'd0;
            state_next = ST_IDLE;
          end else begin
            skip_next  = skip_cnt - 8'd1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          skip_next  = 8'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Matrix update
  // --------------------------------------------------------------------------
  always_comb begin
    kbmat_next = kbmat;
    if (do_clear) begin
      kbmat_next = KBMAT_IDLE;
    end else if (hit && is_make) begin
      kbmat_next[idx] = 1'b0;
    end else if (hit && is_break) begin
      kbmat_next[idx] = 1'b1;
    end
  end

  // key_event is registered alongside kbmat so it marks exactly the first
  // cycle of the new value; typematic repeats leave kbmat_next == kbmat.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbmat     <= KBMAT_IDLE;
      key_event <= 1'b0;
    end else begin
      kbmat     <= kbmat_next;
      key_event <= (kbmat_next != kbmat);
    end
  end

endmodule : kbd_matrix
`default_nettype wire

// File: tb/tb_kbd_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_matrix
//  Purpose  : Self-checking bench for kbd_matrix. Stimulus pushes expected
//             matrix values (with the cycle they must appear) into queues;
//             a negedge monitor pops and compares on every key_event and at
//             requested snapshot cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_matrix;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic [63:0] kbmat;
  logic        key_event;

  kbd_matrix #(
    .CLEAR_ON_ERROR (1),
    .PAUSE_SKIP     (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .kbmat      (kbmat),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] mat;
    int unsigned at;
  } exp_t;

  exp_t evq[$];   // expected key_event pulses
  exp_t snq[$];   // expected quiet-state snapshots

  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  logic [63:0] m;  // hand-maintained expected matrix

  // Drive one byte; when evt=1 a key_event carrying m is expected one cycle
  // after the sampling edge.
  task automatic send(input logic [7:0] b, input bit evt);
    exp_t e;
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
    if (evt) begin
      e.mat = m;
      e.at  = cyc + 1;
      evq.push_back(e);
    end
    @(posedge clk);
    #1 scan_valid = 1'b0;
  endtask

  // Request a full-matrix comparison (and key_event==0) on the next negedge.
  task automatic snap();
    exp_t e;
    @(negedge clk);
    e.mat = m;
    e.at  = cyc + 1;
    snq.push_back(e);
  endtask

  // One-cycle reset with a strobe that must be ignored.
  task automatic pulse_reset();
    @(negedge clk);
    reset      = 1'b1;
    scan_valid = 1'b1;
    scan_code  = 8'hE0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    scan_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (key_event) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: key_event=1 at cycle %0d kbmat=%h, required no event",
                 cyc, kbmat);
      end else begin
        e = evq.pop_front();
        if (kbmat !== e.mat || e.at != cyc) begin
          errors++;
          $display("FAIL event: cycle %0d kbmat=%h, required cycle %0d kbmat=%h",
                   cyc, kbmat, e.at, e.mat);
        end
      end
    end else if (evq.size() != 0 && evq[0].at <= cyc) begin
      checks++;
      errors++;
      e = evq.pop_front();
      $display("FAIL missed_event: no key_event at cycle %0d, required kbmat=%h",
               e.at, e.mat);
    end

    if (snq.size() != 0 && snq[0].at == cyc) begin
      checks++;
      e = snq.pop_front();
      if (kbmat !== e.mat || key_event !== 1'b0) begin
        errors++;
        $display("FAIL snapshot: cycle %0d kbmat=%h key_event=%b, required kbmat=%h key_event=0",
                 cyc, kbmat, key_event, e.mat);
      end
    end

    if (done) begin
      checks++;
      if (evq.size() != 0 || snq.size() != 0) begin
        errors++;
        $display("FAIL pending: %0d events and %0d snapshots outstanding, required 0",
                 evq.size(), snq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    m = '1;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    snap();
    @(negedge clk);
    reset = 1'b0;
    snap();

    // Single key: A make then break
    m[44] = 1'b0; send(8'h1C, 1'b1);
    repeat (2) @(negedge clk);
    send(8'hF0, 1'b0);
    m[44] = 1'b1; send(8'h1C, 1'b1);

    // Extended key: E0 alone leaves the matrix untouched
    send(8'hE0, 1'b0);
    snap();
    m[3] = 1'b0; send(8'h75, 1'b1);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    m[3] = 1'b1; send(8'h75, 1'b1);
    // Plain 75 is keypad 8, never cursor up
    m[12] = 1'b0; send(8'h75, 1'b1);
    snap();
    send(8'hF0, 1'b0);
    m[12] = 1'b1; send(8'h75, 1'b1);

    // Two keys with typematic repeat
    m[62] = 1'b0; send(8'h12, 1'b1);
    m[44] = 1'b0; send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    snap();

    // Self-test byte releases everything; reset abandons a pending E0
    m = '1; send(8'hAA, 1'b1);
    send(8'hE0, 1'b0);
    pulse_reset();
    m[12] = 1'b0; send(8'h75, 1'b1);
    snap();
    send(8'hF0, 1'b0);
    m[12] = 1'b1; send(8'h75, 1'b1);

    // Pause sequence is swallowed, next byte decodes normally
    foreach (pause_seq[i]) send(pause_seq[i], 1'b0);
    snap();
    m[5] = 1'b0; send(8'h29, 1'b1);

    // Fake shifts are ignored; Enter make/break
    send(8'hE0, 1'b0); send(8'h12, 1'b0);
    send(8'hE0, 1'b0); send(8'h59, 1'b0);
    snap();
    m[6] = 1'b0; send(8'h5A, 1'b1);
    send(8'hF0, 1'b0);
    m[6] = 1'b1; send(8'h5A, 1'b1);

    // Back-to-back F0 1C after a make
    m[44] = 1'b0; send(8'h1C, 1'b1);
    send(8'hF0, 1'b0);
    m[44] = 1'b1; send(8'h1C, 1'b1);

    // Prefix restart: F0 then E0 75 is an extended make
    send(8'hF0, 1'b0);
    send(8'hE0, 1'b0);
    m[3] = 1'b0; send(8'h75, 1'b1);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    m[3] = 1'b1; send(8'h75, 1'b1);

    // Error bytes: FF with Space held clears, 00/FC on idle matrix are quiet
    m = '1; send(8'hFF, 1'b1);
    send(8'h00, 1'b0);
    send(8'hFC, 1'b0);
    snap();

    repeat (4) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kbd_matrix
`default_nettype wire
